clb_multi: RTL and testbench
============================

CLB_MULTI -- requirements
Module: clb_multi

Interface
REQ-001 SHALL have parameter N_TRK, default 2: tracks per side, one BLE (4-LUT + FF) per track, range 1..8.
REQ-002 SHALL have derived constant CFG_BITS = 24*N_TRK: configuration chain length.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_en  input  1  shift enable for the configuration chain.
REQ-006 SHALL have port cfg_si  input  1  serial configuration data in.
REQ-007 SHALL have port cfg_commit  input  1  request to copy the shadow chain into the active config.
REQ-008 SHALL have port cfg_so  output  1  serial data out, the chain MSB, for daisy-chaining.
REQ-009 SHALL have port configured  output  1  high once a commit has succeeded.
REQ-010 SHALL have port cfg_err  output  1  one-cycle pulse when a commit is rejected.
REQ-011 SHALL have ports up_i, down_i, right_i, left_i  input  N_TRK  track inputs per side.
REQ-012 SHALL have ports up_o, down_o, right_o, left_o  output  N_TRK  track outputs per side.

Function
REQ-013 SHALL hold a per-BLE config field at shadow/active[24*i +: 24]: [23] ff_init, [22:19] out_sel (up, down, right, left), [18] o_mux (1 = LUT, 0 = FF), [17:16] ff_en_ctrl, [15:0] lut.
REQ-014 SHALL, when cfg_en=1, shift: shadow <= {shadow[CFG_BITS-2:0], cfg_si}; cfg_so = shadow[CFG_BITS-1], so the first bit shifted in lands at the MSB.
REQ-015 SHALL keep bit_cnt saturating at CFG_BITS and run an FSM: EMPTY -cfg_en-> SHIFTING; SHIFTING -> FULL when bit_cnt reaches CFG_BITS; FULL stays FULL on further shifts (daisy-chain safe).
REQ-016 SHALL, on cfg_commit=1 in FULL with cfg_en=0, in the same edge: active <= shadow, each BLE FF <= its ff_init, configured <= 1, bit_cnt <= 0, FSM -> EMPTY; shadow is retained.
REQ-017 SHALL, on cfg_commit in EMPTY or SHIFTING, or with cfg_en=1 in the same cycle: ignore the commit, pulse cfg_err on the next cycle, and still perform any requested shift.
REQ-018 SHALL leave active config and logic operation undisturbed while shifting; new config takes effect only on a commit.
REQ-019 SHALL compute the BLE i LUT address as {up_i[i], down_i[i], right_i[i], left_i[i]}; lut_out = lut[addr] combinationally.
REQ-020 SHALL select the BLE i FF enable by ff_en_ctrl: 00 left_i[i], 01 right_i[i], 10 constant 1, 11 up_i[i]; an enabled FF loads lut_out each edge.
REQ-021 SHALL set sig = o_mux ? lut_out : ff_q; LUT mode is a zero-cycle path, FF mode has 1-cycle latency.
REQ-022 SHALL drive up_o[i] = out_sel[3] ? sig : down_i[i]; down_o = out_sel[2] ? sig : up_i; right_o = out_sel[1] ? sig : left_i; left_o = out_sel[0] ? sig : right_i.
REQ-023 SHALL hold all FFs at 0 and not update them while configured=0, so an all-zero active config gives pure pass-through.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear shadow, active, all BLE FFs, bit_cnt, cfg_so, configured and cfg_err, and set FSM = EMPTY.
REQ-025 SHALL abandon any shift or commit in progress at reset; the first edge after deassertion behaves as from EMPTY.

Structure
REQ-026 SHALL place in shared package clb_pkg: BLE_CFG_W = 24, packed struct ble_cfg_t (fields per REQ-013), enum ff_en_sel_e, and enum cfg_state_e {EMPTY, SHIFTING, FULL}.
REQ-027 SHALL implement one BLE (LUT, enable mux, FF, output muxes) as sub-module clb_ble, generate-instantiated N_TRK times.
REQ-028 SHALL keep the FSM, counter and shadow/active registers in clb_multi.

Verification
REQ-029 SHALL check: reset, then up_i=2'b01 and down_i=2'b10 with no config -> down_o=2'b01, up_o=2'b10, configured=0, cfg_err=0.
REQ-030 SHALL check: N_TRK=2, shift 48 bits with BLE0 lut=16'h8000, o_mux=1, out_sel=4'b0010, then commit -> configured=1; all BLE0 inputs 1 gives right_o[0]=1; any input 0 gives 0.
REQ-031 SHALL check: commit after 47 shifts -> cfg_err high 1 cycle, configured stays 0, outputs stay pass-through.
REQ-032 SHALL check: FF mode, ff_en_ctrl=01, ff_init=1 -> q=1 right after commit; with right_i[i]=0 q holds; with right_i[i]=1 q loads lut_out one edge later.
REQ-033 SHALL check: two chained instances, 96 shifts, shared commit -> both configured; cfg_so of the first equals cfg_si delayed 48 cycles.
REQ-034 SHALL check: rst_n pulsed low mid-shift (bit 20) -> immediate clear; a fresh 48-bit load and commit then succeeds.

Source files
------------

// File: rtl/clb_pkg.sv
// Shared types and constants for the multi-track configurable logic block.
package clb_pkg;

    localparam int unsigned BLE_CFG_W = 24;

    // Source of the BLE flip-flop enable.
    typedef enum logic [1:0] {
        FF_EN_LEFT  = 2'b00,
        FF_EN_RIGHT = 2'b01,
        FF_EN_ONE   = 2'b10,
        FF_EN_UP    = 2'b11
    } ff_en_sel_e;

    // Configuration chain occupancy.
    typedef enum logic [1:0] {
        EMPTY    = 2'b00,
        SHIFTING = 2'b01,
        FULL     = 2'b10
    } cfg_state_e;

    // Per-BLE configuration field, MSB first.
    typedef struct packed {
        logic       ff_init;
        logic [3:0] out_sel;    // up, down, right, left
        logic       o_mux;      // 1 = LUT, 0 = FF
        ff_en_sel_e ff_en_ctrl;
        logic [15:0] lut;
    } ble_cfg_t;

endpackage

// File: rtl/clb_ble.sv
// One basic logic element: 4-LUT, enable mux, flip-flop and track output muxes.
module clb_ble
    import clb_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  ble_cfg_t cfg,
    input  logic     configured,
    input  logic     commit,
    input  logic     init_val,
    input  logic     up_i,
    input  logic     down_i,
    input  logic     right_i,
    input  logic     left_i,
    output logic     up_o,
    output logic     down_o,
    output logic     right_o,
    output logic     left_o
);

    logic [3:0] addr;
    logic       lut_out;
    logic       ff_en;
    logic       ff_q;
    logic       sig;
    // ff_init is taken from the incoming shadow copy at commit time, not from cfg.
    logic       unused_ff_init;

    assign unused_ff_init = cfg.ff_init;
    assign addr           = {up_i, down_i, right_i, left_i};
    assign lut_out        = cfg.lut[addr];

    // Flip-flop enable source selection.
    always_comb begin
        ff_en = 1'b0;
        case (cfg.ff_en_ctrl)
            FF_EN_LEFT:  ff_en = left_i;
            FF_EN_RIGHT: ff_en = right_i;
            FF_EN_ONE:   ff_en = 1'b1;
            FF_EN_UP:    ff_en = up_i;
            default:     ff_en = 1'b0;
        endcase
    end

    // BLE flip-flop: preset on commit, frozen until the block is configured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_q <= 1'b0;
        end else if (commit) begin
            ff_q <= init_val;
        end else if (configured && ff_en) begin
            ff_q <= lut_out;
        end
    end

    assign sig     = cfg.o_mux ? lut_out : ff_q;
    assign up_o    = cfg.out_sel[3] ? sig : down_i;
    assign down_o  = cfg.out_sel[2] ? sig : up_i;
    assign right_o = cfg.out_sel[1] ? sig : left_i;
    assign left_o  = cfg.out_sel[0] ? sig : right_i;

endmodule

// File: rtl/clb_multi.sv
// Multi-track CLB: serial shadow configuration chain, atomic commit, N_TRK BLEs.
module clb_multi
    import clb_pkg::*;
#(
    parameter int unsigned N_TRK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_en,
    input  logic             cfg_si,
    input  logic             cfg_commit,
    output logic             cfg_so,
    output logic             configured,
    output logic             cfg_err,
    input  logic [N_TRK-1:0] up_i,
    input  logic [N_TRK-1:0] down_i,
    input  logic [N_TRK-1:0] right_i,
    input  logic [N_TRK-1:0] left_i,
    output logic [N_TRK-1:0] up_o,
    output logic [N_TRK-1:0] down_o,
    output logic [N_TRK-1:0] right_o,
    output logic [N_TRK-1:0] left_o
);

    localparam int unsigned CFG_BITS = BLE_CFG_W * N_TRK;
    localparam int unsigned CNT_W    = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] active;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    cnt_next;
    cfg_state_e          state;
    cfg_state_e          state_next;
    logic                commit_ok;
    logic                commit_bad;

    // Chain state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Commit qualification, bit counter and chain state transitions.
    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        commit_ok  = 1'b0;
        commit_bad = 1'b0;
        if (cfg_commit) begin
            if ((state == FULL) && !cfg_en) begin
                commit_ok = 1'b1;
            end else begin
                commit_bad = 1'b1;
            end
        end
        if (commit_ok) begin
            cnt_next   = '0;
            state_next = EMPTY;
        end else if (cfg_en) begin
            if (bit_cnt != FULL_CNT) begin
                cnt_next = bit_cnt + CNT_W'(1);
            end
            case (state)
                EMPTY, SHIFTING: state_next = (cnt_next == FULL_CNT) ? FULL : SHIFTING;
                FULL:            state_next = FULL;
                default:         state_next = EMPTY;
            endcase
        end
    end

    // Shadow chain, active config, counter and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            active     <= '0;
            bit_cnt    <= '0;
            configured <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            bit_cnt <= cnt_next;
            cfg_err <= commit_bad;
            if (cfg_en) begin
                shadow <= {shadow[CFG_BITS-2:0], cfg_si};
            end
            if (commit_ok) begin
                active     <= shadow;
                configured <= 1'b1;
            end
        end
    end

    assign cfg_so = shadow[CFG_BITS-1];

    // One BLE per track.
    for (genvar i = 0; i < int'(N_TRK); i++) begin : g_ble
        clb_ble u_ble (
            .clk        (clk),
            .rst_n      (rst_n),
            .cfg        (ble_cfg_t'(active[BLE_CFG_W*i +: BLE_CFG_W])),
            .configured (configured),
            .commit     (commit_ok),
            .init_val   (shadow[BLE_CFG_W*i + BLE_CFG_W - 1]),
            .up_i       (up_i[i]),
            .down_i     (down_i[i]),
            .right_i    (right_i[i]),
            .left_i     (left_i[i]),
            .up_o       (up_o[i]),
            .down_o     (down_o[i]),
            .right_o    (right_o[i]),
            .left_o     (left_o[i])
        );
    end

endmodule

// File: tb/tb_clb_multi.sv
// Directed bench for clb_multi: pass-through, LUT/FF modes, commit rules, daisy chain, reset.
module tb_clb_multi;
    import clb_pkg::*;

    localparam int unsigned N = 2;

    logic         clk;
    logic         rst_n;
    logic         cfg_en;
    logic         cfg_si;
    logic         cfg_commit;
    logic         so0, conf0, err0;
    logic         so1, conf1, err1;
    logic [N-1:0] up_i, down_i, right_i, left_i;
    logic [N-1:0] up_o, down_o, right_o, left_o;
    logic [N-1:0] up_i1, down_i1, right_i1, left_i1;
    logic [N-1:0] up_o1, down_o1, right_o1, left_o1;

    int n_checks;
    int n_errors;

    logic [47:0] w_and;
    logic [47:0] w_ff;
    logic [47:0] w_one;
    logic [95:0] v_chain;
    ble_cfg_t    c;

    clb_multi #(.N_TRK(N)) u0 (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_si(cfg_si), .cfg_commit(cfg_commit),
        .cfg_so(so0), .configured(conf0), .cfg_err(err0),
        .up_i(up_i), .down_i(down_i), .right_i(right_i), .left_i(left_i),
        .up_o(up_o), .down_o(down_o), .right_o(right_o), .left_o(left_o)
    );

    clb_multi #(.N_TRK(N)) u1 (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_si(so0), .cfg_commit(cfg_commit),
        .cfg_so(so1), .configured(conf1), .cfg_err(err1),
        .up_i(up_i1), .down_i(down_i1), .right_i(right_i1), .left_i(left_i1),
        .up_o(up_o1), .down_o(down_o1), .right_o(right_o1), .left_o(left_o1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [N-1:0] u, input logic [N-1:0] d,
                          input logic [N-1:0] r, input logic [N-1:0] l);
        up_i = u; down_i = d; right_i = r; left_i = l;
        #1;
    endtask

    task automatic do_reset();
        cfg_en = 1'b0; cfg_commit = 1'b0; cfg_si = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    // Shift n bits of w, MSB first, starting at bit (47 - from).
    task automatic shift_bits(input logic [47:0] w, input int from, input int n);
        for (int k = 0; k < n; k++) begin
            cfg_en = 1'b1;
            cfg_si = w[47 - from - k];
            tick();
        end
        cfg_en = 1'b0;
        #1;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        up_i = '0; down_i = '0; right_i = '0; left_i = '0;
        up_i1 = '0; down_i1 = '0; right_i1 = '0; left_i1 = '0;

        c = '{ff_init: 1'b0, out_sel: 4'b0010, o_mux: 1'b1, ff_en_ctrl: FF_EN_LEFT, lut: 16'h8000};
        w_and = {24'h0, c};
        c = '{ff_init: 1'b1, out_sel: 4'b0010, o_mux: 1'b0, ff_en_ctrl: FF_EN_RIGHT, lut: 16'hF0F0};
        w_ff = {24'h0, c};
        c = '{ff_init: 1'b0, out_sel: 4'b1000, o_mux: 1'b1, ff_en_ctrl: FF_EN_LEFT, lut: 16'hFFFF};
        w_one = {24'h0, c};
        v_chain = {w_one, w_and};

        // Reset state and unconfigured pass-through.
        do_reset();
        check("rst_configured", conf0, 1'b0);
        check("rst_cfg_err", err0, 1'b0);
        check("rst_cfg_so", so0, 1'b0);
        set_in(2'b01, 2'b10, 2'b01, 2'b10);
        check("pt_down_o", down_o, 2'b01);
        check("pt_up_o", up_o, 2'b10);
        check("pt_right_o", right_o, 2'b10);
        check("pt_left_o", left_o, 2'b01);

        // Commit after only 47 bits is rejected.
        shift_bits(w_and, 0, 47);
        commit();
        check("short_err_pulse", err0, 1'b1);
        check("short_configured", conf0, 1'b0);
        check("short_pt_right_o", right_o, 2'b10);
        check("short_pt_up_o", up_o, 2'b10);
        tick();
        check("short_err_clear", err0, 1'b0);

        // Commit together with a shift is rejected but the shift lands; a clean commit follows.
        do_reset();
        set_in(2'b00, 2'b00, 2'b00, 2'b00);
        shift_bits(w_and, 0, 47);
        cfg_en = 1'b1; cfg_si = w_and[0]; cfg_commit = 1'b1;
        tick();
        cfg_en = 1'b0; cfg_commit = 1'b0;
        #1;
        check("shift_commit_err", err0, 1'b1);
        check("shift_commit_cfg", conf0, 1'b0);
        commit();
        check("and_configured", conf0, 1'b1);
        check("and_err", err0, 1'b0);
        set_in(2'b01, 2'b01, 2'b01, 2'b01);
        check("and_all1", right_o, 2'b01);
        check("and_up_pt", up_o, 2'b01);
        set_in(2'b01, 2'b01, 2'b01, 2'b00);
        check("and_left0", right_o, 2'b00);
        set_in(2'b00, 2'b01, 2'b01, 2'b01);
        check("and_up0", right_o, 2'b00);
        set_in(2'b01, 2'b00, 2'b01, 2'b01);
        check("and_down0", right_o, 2'b00);

        // FF mode with right_i enable and ff_init = 1.
        do_reset();
        set_in(2'b00, 2'b00, 2'b00, 2'b00);
        shift_bits(w_ff, 0, 48);
        commit();
        check("ff_configured", conf0, 1'b1);
        check("ff_init_q", right_o, 2'b01);
        tick();
        check("ff_hold_en0", right_o, 2'b01);
        set_in(2'b00, 2'b00, 2'b01, 2'b00);
        check("ff_pre_edge", right_o, 2'b01);
        tick();
        check("ff_load0", right_o, 2'b00);
        set_in(2'b00, 2'b01, 2'b00, 2'b00);
        tick();
        check("ff_hold0", right_o, 2'b00);
        set_in(2'b00, 2'b01, 2'b01, 2'b00);
        tick();
        check("ff_load1", right_o, 2'b01);

        // Two chained instances, 96 shifts, shared commit.
        do_reset();
        set_in(2'b00, 2'b00, 2'b00, 2'b00);
        for (int j = 0; j < 96; j++) begin
            cfg_en = 1'b1;
            cfg_si = v_chain[95 - j];
            #1;
            if (j >= 48) check("so_delay48", so0, v_chain[95 - j + 48]);
            tick();
        end
        cfg_en = 1'b0;
        #1;
        check("chain_so1", so1, w_one[47]);
        commit();
        check("chain_conf0", conf0, 1'b1);
        check("chain_conf1", conf1, 1'b1);
        check("chain_err1", err1, 1'b0);
        check("chain_u1_up_o", up_o1, 2'b01);
        check("chain_u1_other", {down_o1, right_o1, left_o1}, 6'b0);
        set_in(2'b01, 2'b01, 2'b01, 2'b01);
        check("chain_u0_and", right_o, 2'b01);

        // Reset mid-shift clears immediately; reload then succeeds.
        set_in(2'b00, 2'b00, 2'b00, 2'b01);
        check("pre_rst_cfg", right_o, 2'b00);
        shift_bits(w_and, 0, 20);
        cfg_en = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_configured", conf0, 1'b0);
        check("midrst_pt", right_o, 2'b01);
        check("midrst_so", so0, 1'b0);
        cfg_en = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        shift_bits(w_and, 0, 47);
        commit();
        check("post_rst_short_err", err0, 1'b1);
        check("post_rst_short_cfg", conf0, 1'b0);
        shift_bits(w_and, 47, 1);
        commit();
        check("post_rst_configured", conf0, 1'b1);
        check("post_rst_err", err0, 1'b0);
        set_in(2'b01, 2'b01, 2'b01, 2'b01);
        check("post_rst_and", right_o, 2'b01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
